// File: rtl/mul_arbiter.sv
// Round-robin front end for a shared multi-cycle multiplier: two requesters,
// one operation in flight, a timeout-guarded wait and a response held for the consumer.
module mul_arbiter #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_product,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a requester; grant and operand capture happen here
  // ISSUE | start pulse to the multiplier, wait counter cleared
  // WAIT  | operands held, counting cycles until mul_done or timeout
  // RESP  | response held until the consumer takes it

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             mul_start_q, mul_start_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic             any_valid;
  logic             grant_id;
  logic             grant;
  logic             timeout_hit;

  // A lone requester wins outright; only contention consults last_grant.
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    grant_id    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    grant       = (state_q == IDLE) & any_valid;
    timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    mul_start_d  = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d      = ISSUE;
          last_grant_d = grant_id;
          resp_id_d    = grant_id;
          op_a_d       = grant_id ? req1_a : req0_a;
          op_b_d       = grant_id ? req1_b : req0_b;
          mul_start_d  = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done arriving on the timeout cycle still counts as success.
        if (mul_done) begin
          resp_data_d  = mul_product;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (timeout_hit) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mul_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      mul_start_q  <= mul_start_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Operands are only presented while the multiplier owns them.
  always_comb begin
    req0_ready = grant & ~grant_id;
    req1_ready = grant & grant_id;
    mul_start  = mul_start_q;
    mul_a      = ((state_q == ISSUE) || (state_q == WAIT)) ? op_a_q : '0;
    mul_b      = ((state_q == ISSUE) || (state_q == WAIT)) ? op_b_q : '0;
    resp_valid = resp_valid_q;
    resp_id    = resp_id_q;
    resp_data  = resp_data_q;
    resp_err   = resp_err_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a transaction-level model of the arbiter.
module tb_mul_arbiter;
  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             mul_start;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             mul_done = 1'b0;
  logic [WIDTH-1:0] mul_product = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic             busy;

  always #5 clk = ~clk;

  mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_val(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  // Transaction-level reference: who should be granted, what comes back.
  typedef struct {
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               err;
  } txn_t;

  txn_t sb_q[$];
  bit   mon_en     = 1'b0;
  bit   mdl_idle   = 1'b1;
  bit   mdl_last   = 1'b1;
  bit   mdl_issue  = 1'b0;

  // Multiplier environment model.
  bit               mm_active = 1'b0;
  bit               mm_never  = 1'b0;
  int               mm_age    = 0;
  int               mm_delay  = 1;
  logic [WIDTH-1:0] mm_a, mm_b;
  int               next_delay = 1;
  bit               next_never = 1'b0;
  bit               rand_mode  = 1'b0;
  bit               force_done = 1'b0;

  // What the DUT actually did.
  logic             g_ids[$];
  int               g_cycs[$];
  logic             r_ids[$];
  logic [WIDTH-1:0] r_data[$];
  logic             r_err[$];
  int               n_starts  = 0;
  int               start_cyc = 0;
  int               lat       = 0;
  bit               prev_rv   = 1'b0;

  task automatic clear_capture();
    g_ids.delete(); g_cycs.delete(); r_ids.delete(); r_data.delete(); r_err.delete();
    n_starts = 0;
  endtask

  task automatic monitor();
    logic g, exp_r0, exp_r1;
    logic [WIDTH-1:0] exp_data;
    txn_t e;
    g      = (req0_valid && req1_valid) ? ~mdl_last : req1_valid;
    exp_r0 = mdl_idle && (req0_valid || req1_valid) && !g;
    exp_r1 = mdl_idle && (req0_valid || req1_valid) && g;
    check_bit("req0_ready", req0_ready, exp_r0);
    check_bit("req1_ready", req1_ready, exp_r1);
    check_bit("busy", busy, !mdl_idle);
    check_bit("mul_start", mul_start, mdl_issue);
    if (mdl_idle) begin
      check_val("mul_a_idle", mul_a, '0);
      check_val("mul_b_idle", mul_b, '0);
      check_bit("resp_valid_idle", resp_valid, 1'b0);
    end
    if (req0_ready || req1_ready) begin
      g_ids.push_back(req1_ready);
      g_cycs.push_back(cyc);
    end
    if (mul_start) begin
      n_starts++;
      start_cyc = cyc;
      mm_active = 1'b1;
      mm_age    = 0;
      mm_a      = mul_a;
      mm_b      = mul_b;
      if (rand_mode) begin
        mm_never = ($urandom_range(0, 15) == 0);
        mm_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : $urandom_range(1, 3);
      end else begin
        mm_never = next_never;
        mm_delay = next_delay;
      end
      if (sb_q.size() > 0) begin
        check_val("mul_a_issue", mul_a, sb_q[0].a);
        check_val("mul_b_issue", mul_b, sb_q[0].b);
        sb_q[0].err = mm_never;
      end
    end
    mdl_issue = 1'b0;
    if (exp_r0 || exp_r1) begin
      e.id  = g;
      e.a   = g ? req1_a : req0_a;
      e.b   = g ? req1_b : req0_b;
      e.err = 1'b0;
      sb_q.push_back(e);
      mdl_last  = g;
      mdl_idle  = 1'b0;
      mdl_issue = 1'b1;
    end
    if (resp_valid && !prev_rv) lat = cyc - start_cyc;
    prev_rv = resp_valid;
    if (resp_valid && resp_ready) begin
      r_ids.push_back(resp_id);
      r_data.push_back(resp_data);
      r_err.push_back(resp_err);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got response id %b data %0h with none outstanding", resp_id, resp_data);
      end else begin
        e = sb_q.pop_front();
        exp_data = e.a * e.b;
        if (e.err) exp_data = '0;
        check_bit("sb_resp_id", resp_id, e.id);
        check_val("sb_resp_data", resp_data, exp_data);
        check_bit("sb_resp_err", resp_err, e.err);
      end
      mdl_idle  = 1'b1;
      mm_active = 1'b0;
    end
  endtask

  // One clock: environment drives at negedge, observes 1ns later, returns just after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mm_active) begin
      mm_age++;
      mul_done    = !mm_never && (mm_age == mm_delay);
      mul_product = mul_done ? (mm_a * mm_b) : {$urandom, $urandom};
      if (mul_done) mm_active = 1'b0;
    end else begin
      mul_done    = force_done || (rand_mode && $urandom_range(0, 7) == 0);
      mul_product = {$urandom, $urandom};
    end
    #1;
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    force_done = 1'b0;
    rand_mode  = 1'b0;
    tick();
    rst       = 1'b0;
    mul_done  = 1'b0;
    mdl_idle  = 1'b1;
    mdl_last  = 1'b1;
    mdl_issue = 1'b0;
    mm_active = 1'b0;
    prev_rv   = 1'b0;
    sb_q.delete();
    check_bit("rst_req0_ready", req0_ready, 1'b0);
    check_bit("rst_req1_ready", req1_ready, 1'b0);
    check_bit("rst_mul_start", mul_start, 1'b0);
    check_val("rst_mul_a", mul_a, '0);
    check_val("rst_mul_b", mul_b, '0);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check_bit("rst_resp_id", resp_id, 1'b0);
    check_val("rst_resp_data", resp_data, '0);
    check_bit("rst_resp_err", resp_err, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    mon_en = 1'b1;
  endtask

  typedef struct {
    logic             v0, v1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    int               delay;
    bit               never;
    logic             exp_id;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic v1,
                              input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                              input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                              input int d, input bit nv, input logic id,
                              input logic [WIDTH-1:0] data, input logic err);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.delay = d; v.never = nv; v.exp_id = id; v.exp_data = data; v.exp_err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    clear_capture();
    req0_valid = v.v0; req1_valid = v.v1;
    req0_a = v.a0; req0_b = v.b0; req1_a = v.a1; req1_b = v.b1;
    resp_ready = 1'b1;
    next_delay = v.delay;
    next_never = v.never;
    for (int i = 0; i < 10 && g_ids.size() == 0; i++) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 100 && r_ids.size() == 0; i++) tick();
    if (g_ids.size() == 0 || r_ids.size() == 0) begin
      fail_now($sformatf("vec%0d_complete", idx));
    end else begin
      check_bit($sformatf("vec%0d_grant", idx), g_ids[0], v.exp_id);
      check_int($sformatf("vec%0d_ready_pulses", idx), g_ids.size(), 1);
      check_int($sformatf("vec%0d_starts", idx), n_starts, 1);
      check_bit($sformatf("vec%0d_resp_id", idx), r_ids[0], v.exp_id);
      check_val($sformatf("vec%0d_resp_data", idx), r_data[0], v.exp_data);
      check_bit($sformatf("vec%0d_resp_err", idx), r_err[0], v.exp_err);
      check_int($sformatf("vec%0d_latency", idx), lat, v.never ? TIMEOUT + 1 : v.delay + 1);
    end
  endtask

  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = mk(1, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 33, 0, 0, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    vecs[1] = mk(1, 1, 64'd2, 64'd2, 64'd7, 64'd6, 1, 0, 1, 64'd42, 0);
    vecs[2] = mk(1, 1, 64'd2, 64'd2, 64'd7, 64'd6, 1, 0, 0, 64'd4, 0);
    vecs[3] = mk(1, 0, 64'd5, 64'd6, 0, 0, TIMEOUT, 0, 0, 64'd30, 0);
    vecs[4] = mk(0, 1, 0, 0, ALL1, ALL1, 1, 1, 1, 64'd0, 1);
    vecs[5] = mk(1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'd1, 2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    vecs[6] = mk(1, 1, 64'd1, 64'd1, 64'h8000_0000_0000_0000, ALL1, 5, 0, 1, 64'h8000_0000_0000_0000, 0);

    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Continuous contention with a zero-wait multiplier.
    do_reset();
    clear_capture();
    req0_a = 64'd2; req0_b = 64'd2; req1_a = 64'd7; req1_b = 64'd6;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    next_delay = 1; next_never = 1'b0;
    for (int i = 0; i < 40 && r_ids.size() < 4; i++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (g_ids.size() < 4 || r_ids.size() < 4) begin
      fail_now("rr_four_txns");
    end else begin
      for (int i = 0; i < 4; i++) begin
        check_bit($sformatf("rr_grant%0d", i), g_ids[i], logic'(i % 2));
        check_bit($sformatf("rr_resp_id%0d", i), r_ids[i], logic'(i % 2));
        check_val($sformatf("rr_resp_data%0d", i), r_data[i], (i % 2 == 1) ? 64'd42 : 64'd4);
      end
      for (int i = 1; i < 4; i++)
        check_int($sformatf("rr_spacing%0d", i), g_cycs[i] - g_cycs[i-1], 4);
    end

    // Back-pressure with a competing requester waiting.
    clear_capture();
    req0_a = 64'd9; req0_b = 64'd9; req0_valid = 1'b1; resp_ready = 1'b0;
    next_delay = 3;
    for (int i = 0; i < 10 && g_ids.size() == 0; i++) tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && !resp_valid; i++) tick();
    if (!resp_valid) fail_now("bp_resp_valid");
    req1_a = 64'd1; req1_b = 64'd1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_bit("bp_valid_held", resp_valid, 1'b1);
      check_val("bp_data_held", resp_data, 64'd81);
      check_bit("bp_id_held", resp_id, 1'b0);
      check_bit("bp_err_held", resp_err, 1'b0);
      check_bit("bp_req1_ready_low", req1_ready, 1'b0);
    end
    next_delay = 2;
    resp_ready = 1'b1;
    tick();
    check_bit("bp_req1_accept", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 20 && r_ids.size() < 2; i++) tick();
    if (r_ids.size() < 2) begin
      fail_now("bp_second_resp");
    end else begin
      check_bit("bp_second_id", r_ids[1], 1'b1);
      check_val("bp_second_data", r_data[1], 64'd1);
    end

    // Reset ten cycles into WAIT, then a stale done.
    clear_capture();
    req0_a = 64'd4; req0_b = 64'd4; req0_valid = 1'b1; resp_ready = 1'b1;
    next_never = 1'b1;
    for (int i = 0; i < 10 && g_ids.size() == 0; i++) tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 5 && n_starts == 0; i++) tick();
    if (n_starts == 0) fail_now("rstw_start");
    repeat (10) tick();
    check_bit("rstw_busy_before", busy, 1'b1);
    do_reset();
    resp_ready = 1'b1;
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bit("rstw_no_resp", resp_valid, 1'b0);
      check_bit("rstw_idle", busy, 1'b0);
    end
    check_int("rstw_resp_count", r_ids.size(), 0);
    next_never = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      resp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rand_mode  = 1'b0;
    next_delay = 1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 200 && (!mdl_idle || sb_q.size() > 0); i++) tick();
    check_int("rand_drain", sb_q.size(), 0);
    check_bit("rand_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
